// File: rtl/ctrl_word_sequencer.sv
// Table-driven control-word sequencer: steps 0..last_step, each held for its dwell+1 cycles.
// Optional SEQ_LOOP_EN adds a `loop` input so the sequence wraps back to step 0 instead of ending.
module ctrl_word_sequencer #(
  parameter int unsigned          W_WIDTH   = 6,
  parameter int unsigned          DEPTH     = 8,
  parameter int unsigned          DWELL_W   = 4,
  parameter logic [W_WIDTH-1:0]   IDLE_WORD = '0,
  localparam int unsigned         AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [AW-1:0]      last_step,
`ifdef SEQ_LOOP_EN
  input  logic               loop,
`endif
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [W_WIDTH-1:0] cfg_word,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [W_WIDTH-1:0] w,
  output logic [AW-1:0]      step,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [AW-1:0]      StepOne = AW'(1);
  localparam logic [DWELL_W-1:0] CntOne  = DWELL_W'(1);

  state_e               state_q, state_d;
  logic [W_WIDTH-1:0]   w_q, w_d;
  logic [AW-1:0]        step_q, step_d;
  logic [AW-1:0]        last_q, last_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 tbl_we;
  logic [AW-1:0]        nxt_step;
  logic [W_WIDTH-1:0]   word_q  [DEPTH];
  logic [DWELL_W-1:0]   dwell_q [DEPTH];
`ifdef SEQ_LOOP_EN
  logic                 loop_q, loop_d;
`endif

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    step_d    = step_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    tbl_we    = 1'b0;
    nxt_step  = step_q + StepOne;
`ifdef SEQ_LOOP_EN
    loop_d    = loop_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A write in the same cycle as start wins; start is dropped.
        if (cfg_we) begin
          tbl_we = 1'b1;
        end else if (start) begin
          state_d = StRun;
          busy_d  = 1'b1;
          step_d  = '0;
          w_d     = word_q[0];
          cnt_d   = dwell_q[0];
          last_d  = last_step;
`ifdef SEQ_LOOP_EN
          loop_d  = loop;
`endif
        end
      end
      StRun: begin
        cfg_err_d = cfg_we;
        if (stop) begin
          state_d = StIdle;
          w_d     = IDLE_WORD;
          busy_d  = 1'b0;
          step_d  = '0;
        end else if (pause) begin
          state_d = StRun;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else if (step_q != last_q) begin
          step_d = nxt_step;
          w_d    = word_q[nxt_step];
          cnt_d  = dwell_q[nxt_step];
`ifdef SEQ_LOOP_EN
        end else if (loop_q) begin
          step_d = '0;
          w_d    = word_q[0];
          cnt_d  = dwell_q[0];
`endif
        end else begin
          state_d = StIdle;
          w_d     = IDLE_WORD;
          busy_d  = 1'b0;
          step_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      w_q       <= IDLE_WORD;
      step_q    <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef SEQ_LOOP_EN
      loop_q    <= 1'b0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i]  <= '0;
        dwell_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      step_q    <= step_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
`ifdef SEQ_LOOP_EN
      loop_q    <= loop_d;
`endif
      if (tbl_we) begin
        word_q[cfg_addr]  <= cfg_word;
        dwell_q[cfg_addr] <= cfg_dwell;
      end
    end
  end

  assign w       = w_q;
  assign step    = step_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// Directed bench for ctrl_word_sequencer: completion, pause, stop, rejected writes, reset, loop.
module tb_ctrl_word_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, cfg_we;
  logic [2:0] last_step, cfg_addr;
  logic [5:0] cfg_word;
  logic [3:0] cfg_dwell;
  logic [5:0] w;
  logic [2:0] step;
  logic       busy, done, cfg_err;
`ifdef SEQ_LOOP_EN
  logic       loop;
`endif

  int total = 0;
  int bad   = 0;

  ctrl_word_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .last_step (last_step),
`ifdef SEQ_LOOP_EN
    .loop      (loop),
`endif
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_word  (cfg_word),
    .cfg_dwell (cfg_dwell),
    .w         (w),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] wd, input logic [3:0] dw);
    cfg_we = 1'b1; cfg_addr = a; cfg_word = wd; cfg_dwell = dw;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  logic [5:0] exp_seq [6];

  initial begin
    exp_seq = '{6'h21, 6'h21, 6'h0C, 6'h12, 6'h12, 6'h12};
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; cfg_we = 1'b0;
    last_step = '0; cfg_addr = '0; cfg_word = '0; cfg_dwell = '0;
`ifdef SEQ_LOOP_EN
    loop = 1'b0;
`endif
    tick();
    tick();
    chk("rst_w", {26'd0, w}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_step", {29'd0, step}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    reset = 1'b0;

    wr(3'd0, 6'h21, 4'd1);
    wr(3'd1, 6'h0C, 4'd0);
    wr(3'd2, 6'h12, 4'd2);

    // Completion
    last_step = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cmp_w%0d", i), {26'd0, w}, {26'd0, exp_seq[i]});
      chk($sformatf("cmp_busy%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("cmp_done%0d", i), {31'd0, done}, 32'd0);
      tick();
    end
    chk("cmp_end_w", {26'd0, w}, 32'h00);
    chk("cmp_end_busy", {31'd0, busy}, 32'd0);
    chk("cmp_end_done", {31'd0, done}, 32'd1);
    tick();
    chk("cmp_done_clr", {31'd0, done}, 32'd0);

    // Pause three cycles during step 0
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pau_w0", {26'd0, w}, 32'h21);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pau_hold%0d", i), {26'd0, w}, 32'h21);
    end
    pause = 1'b0;
    for (int i = 1; i < 6; i++) begin
      tick();
      chk($sformatf("pau_w%0d", i), {26'd0, w}, {26'd0, exp_seq[i]});
      chk($sformatf("pau_done%0d", i), {31'd0, done}, 32'd0);
    end
    tick();
    chk("pau_end_done", {31'd0, done}, 32'd1);
    chk("pau_end_busy", {31'd0, busy}, 32'd0);
    tick();

    // Stop while w=0C
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("stp_pre_w", {26'd0, w}, 32'h0C);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stp_w", {26'd0, w}, 32'h00);
    chk("stp_busy", {31'd0, busy}, 32'd0);
    chk("stp_step", {29'd0, step}, 32'd0);
    chk("stp_done", {31'd0, done}, 32'd0);
    tick();
    chk("stp_done2", {31'd0, done}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stp_restart_w", {26'd0, w}, 32'h21);
    wait_done("stp_restart_done");
    tick();

    // Rejected write during RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_word = 6'h3F; cfg_dwell = 4'hF;
    tick();
    cfg_we = 1'b0;
    chk("rej_err", {31'd0, cfg_err}, 32'd1);
    tick();
    chk("rej_err_clr", {31'd0, cfg_err}, 32'd0);
    chk("rej_step1_w", {26'd0, w}, 32'h0C);
    wait_done("rej_done");
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rej_rerun_step", {29'd0, step}, 32'd1);
    chk("rej_rerun_w", {26'd0, w}, 32'h0C);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // cfg_we with start in IDLE: write wins
    last_step = 3'd3; start = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_word = 6'h2A; cfg_dwell = 4'd0;
    tick();
    cfg_we = 1'b0;
    chk("col_busy", {31'd0, busy}, 32'd0);
    chk("col_cfg_err", {31'd0, cfg_err}, 32'd0);
    tick();
    start = 1'b0;
    chk("col_run_busy", {31'd0, busy}, 32'd1);
    for (int n = 0; n < 20 && step !== 3'd3; n++) tick();
    chk("col_step3_w", {26'd0, w}, 32'h2A);
    wait_done("col_done");
    tick();

`ifdef SEQ_LOOP_EN
    // Loop: wraps after step 2 with no done
    last_step = 3'd2; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lp_w%0d", i), {26'd0, w}, {26'd0, exp_seq[i % 6]});
      chk($sformatf("lp_busy%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("lp_done%0d", i), {31'd0, done}, 32'd0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("lp_stop_busy", {31'd0, busy}, 32'd0);
    chk("lp_stop_w", {26'd0, w}, 32'h00);
`endif

    // Reset during step 1 clears the table
    last_step = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rmr_pre_step", {29'd0, step}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmr_w", {26'd0, w}, 32'h00);
    chk("rmr_busy", {31'd0, busy}, 32'd0);
    chk("rmr_done", {31'd0, done}, 32'd0);
    last_step = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rmr_run_busy", {31'd0, busy}, 32'd1);
    chk("rmr_run_w", {26'd0, w}, 32'h00);
    tick();
    chk("rmr_end_busy", {31'd0, busy}, 32'd0);
    chk("rmr_end_done", {31'd0, done}, 32'd1);
    tick();
    chk("rmr_done_clr", {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
